// File: rtl/param_restoring_divider.sv
// -----------------------------------------------------------------------------
// param_restoring_divider
//
// Multi-cycle restoring divider computing
//     Q = floor(A * 2^SHIFT / B),  R = (A * 2^SHIFT) mod B
// retiring BPC (1 or 2) quotient bits per cycle over ITER = QW/BPC cycles.
// This is the mantissa divide engine of the FP divide datapath; the default
// parameters give 53-bit mantissas and a 56-bit quotient with guard/round/
// sticky headroom.
//
// Parameters
//   W      operand width of A and B, and width of R
//   QW     quotient width (multiple of BPC)
//   SHIFT  left shift applied to A (SHIFT <= QW)
//   BPC    quotient bits per cycle (1 or 2)
//   TAG_W  sideband tag width (>= 1)
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   in_valid / in_ready        operand handshake (in_ready combinational)
//   dividend, divisor, tag_in  operands A, B and pass-through tag
//   out_valid / out_ready      result handshake with backpressure
//   quotient, remainder        Q and R
//   sticky                     |R
//   dbz                        divisor was zero (Q = all ones, R = 0)
//   ovf                        quotient would not fit QW bits (Q = all ones)
//   tag_out                    tag captured with the operands of this result
// -----------------------------------------------------------------------------
module param_restoring_divider #(
    parameter int W     = 53,
    parameter int QW    = 56,
    parameter int SHIFT = 55,
    parameter int BPC   = 1,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     dividend,
    input  logic [W-1:0]     divisor,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [QW-1:0]    quotient,
    output logic [W-1:0]     remainder,
    output logic             sticky,
    output logic             dbz,
    output logic             ovf,
    output logic [TAG_W-1:0] tag_out
);

    localparam int ITER  = QW / BPC;
    localparam int CNT_W = $clog2(ITER + 1);
    // Wide enough to hold A << SHIFT for any legal SHIFT <= QW.
    localparam int LW    = W + QW;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [W-1:0]     p_q,         p_d;       // partial remainder
    logic [W-1:0]     b_q,         b_d;       // captured divisor
    logic [QW-1:0]    qsr_q,       qsr_d;     // dividend bits out / quotient bits in
    logic [TAG_W-1:0] tag_q,       tag_d;
    logic [QW-1:0]    quotient_q,  quotient_d;
    logic [W-1:0]     remainder_q, remainder_d;
    logic             sticky_q,    sticky_d;
    logic             dbz_q,       dbz_d;
    logic             ovf_q,       ovf_d;
    logic [TAG_W-1:0] tag_out_q,   tag_out_d;

    logic             accept;
    logic [LW-1:0]    load_ext;
    logic [W-1:0]     p0;
    logic [QW-1:0]    qsr0;

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        if (!reset) begin
            if (state_q == ST_IDLE) begin
                in_ready = 1'b1;
            end else if (state_q == ST_DONE) begin
                in_ready = out_ready;
            end
        end
    end

    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);

    // -------------------------------------------------------------------------
    // Load value {A, SHIFT zeros}: the part above bit QW is the initial partial
    // remainder, the low QW bits are consumed MSB first by the shift register.
    // -------------------------------------------------------------------------
    assign load_ext = LW'(dividend) << SHIFT;
    assign p0       = load_ext[LW-1:QW];
    assign qsr0     = load_ext[QW-1:0];

    // -------------------------------------------------------------------------
    // BPC restoring steps chained combinationally. Each step shifts the next
    // dividend bit into the remainder, trial-subtracts B and keeps the
    // difference when it is non-negative. The quotient bit enters the LSB of
    // the same register the dividend bit left from its MSB.
    // -------------------------------------------------------------------------
    logic [W-1:0]  p_stage  [BPC+1];
    logic [QW-1:0] sr_stage [BPC+1];

    assign p_stage[0]  = p_q;
    assign sr_stage[0] = qsr_q;

    generate
        for (genvar gi = 0; gi < BPC; gi++) begin : g_step
            logic [W:0] pp;
            logic [W:0] dd;
            logic       qb;

            assign pp = {p_stage[gi], sr_stage[gi][QW-1]};
            assign dd = pp - {1'b0, b_q};
            // With P < B, P' < 2B, so bit W of the difference is a clean sign.
            assign qb = ~dd[W];
            assign p_stage[gi+1]  = qb ? dd[W-1:0] : pp[W-1:0];
            assign sr_stage[gi+1] = (sr_stage[gi] << 1) | QW'(qb);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        p_d         = p_q;
        b_d         = b_q;
        qsr_d       = qsr_q;
        tag_d       = tag_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        sticky_d    = sticky_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        tag_out_d   = tag_out_q;

        case (state_q)
            ST_IDLE: begin
                // Loads are handled below, shared with the DONE same-edge accept.
            end
            ST_CALC: begin
                p_d   = p_stage[BPC];
                qsr_d = sr_stage[BPC];
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = ST_DONE;
                    quotient_d  = sr_stage[BPC];
                    remainder_d = p_stage[BPC];
                    sticky_d    = |p_stage[BPC];
                    dbz_d       = 1'b0;
                    ovf_d       = 1'b0;
                    tag_out_d   = tag_q;
                end
            end
            ST_DONE: begin
                if (out_ready && !in_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new operation may start from IDLE or on the same edge a result
        // transfers out of DONE; in_ready already encodes both cases.
        if (accept) begin
            b_d   = divisor;
            tag_d = tag_in;
            p_d   = p0;
            qsr_d = qsr0;
            if (divisor == '0) begin
                state_d     = ST_DONE;
                cnt_d       = '0;
                quotient_d  = '1;
                remainder_d = '0;
                sticky_d    = 1'b0;
                dbz_d       = 1'b1;
                ovf_d       = 1'b0;
                tag_out_d   = tag_in;
            end else if (p0 >= divisor) begin
                // First quotient bit would land above bit QW-1.
                state_d     = ST_DONE;
                cnt_d       = '0;
                quotient_d  = '1;
                remainder_d = '0;
                sticky_d    = 1'b0;
                dbz_d       = 1'b0;
                ovf_d       = 1'b1;
                tag_out_d   = tag_in;
            end else begin
                state_d = ST_CALC;
                cnt_d   = CNT_W'(ITER);
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            p_q         <= '0;
            b_q         <= '0;
            qsr_q       <= '0;
            tag_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            sticky_q    <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            tag_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            b_q         <= b_d;
            qsr_q       <= qsr_d;
            tag_q       <= tag_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            sticky_q    <= sticky_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
            tag_out_q   <= tag_out_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign sticky    = sticky_q;
    assign dbz       = dbz_q;
    assign ovf       = ovf_q;
    assign tag_out   = tag_out_q;

endmodule

// File: tb/tb_param_restoring_divider.sv
// -----------------------------------------------------------------------------
// Testbench for param_restoring_divider.
// dut  : default parameters (BPC=1, ITER=56)
// dut2 : BPC=2 (ITER=28)
// Directed table vectors with hand-computed results, backpressure, mid-CALC
// reset, BPC=2 latency, and a random run against a wide-division reference.
// -----------------------------------------------------------------------------
module tb_param_restoring_divider;

    localparam int W     = 53;
    localparam int QW    = 56;
    localparam int TAG_W = 4;
    localparam int N_RND = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]     dividend, divisor, remainder;
    logic [TAG_W-1:0] tag_in, tag_out;
    logic [QW-1:0]    quotient;
    logic             sticky, dbz, ovf;

    logic             in_valid_2, in_ready_2, out_valid_2, out_ready_2;
    logic [W-1:0]     dividend_2, divisor_2, remainder_2;
    logic [TAG_W-1:0] tag_in_2, tag_out_2;
    logic [QW-1:0]    quotient_2;
    logic             sticky_2, dbz_2, ovf_2;

    param_restoring_divider dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder),
        .sticky(sticky), .dbz(dbz), .ovf(ovf), .tag_out(tag_out)
    );

    param_restoring_divider #(.BPC(2)) dut2 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid_2), .in_ready(in_ready_2),
        .dividend(dividend_2), .divisor(divisor_2), .tag_in(tag_in_2),
        .out_valid(out_valid_2), .out_ready(out_ready_2),
        .quotient(quotient_2), .remainder(remainder_2),
        .sticky(sticky_2), .dbz(dbz_2), .ovf(ovf_2), .tag_out(tag_out_2)
    );

    typedef struct {
        logic [W-1:0]     a;
        logic [W-1:0]     b;
        logic [TAG_W-1:0] tag;
        logic [QW-1:0]    q;
        logic [W-1:0]     r;
        logic             st;
        logic             dz;
        logic             ov;
        int               lat;
    } vec_t;

    typedef struct {
        logic [W-1:0]     a;
        logic [W-1:0]     b;
        logic [TAG_W-1:0] tag;
        logic [QW-1:0]    q;
        logic [W-1:0]     r;
    } sb_t;

    int  n_cmp = 0;
    int  n_bad = 0;
    sb_t sb[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Present one vector to dut, wait for the result and compare everything.
    task automatic apply_vec(input vec_t v, input logic rdy, input string nm);
        int guard;
        int lat;
        @(negedge clk);
        dividend  = v.a;
        divisor   = v.b;
        tag_in    = v.tag;
        in_valid  = 1'b1;
        out_ready = rdy;
        #1;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        chk({nm, "_in_ready"}, 128'(in_ready), 128'(1));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"}, 128'(lat), 128'(v.lat));
        chk({nm, "_q"}, 128'(quotient), 128'(v.q));
        chk({nm, "_r"}, 128'(remainder), 128'(v.r));
        chk({nm, "_sticky"}, 128'(sticky), 128'(v.st));
        chk({nm, "_dbz"}, 128'(dbz), 128'(v.dz));
        chk({nm, "_ovf"}, 128'(ovf), 128'(v.ov));
        chk({nm, "_tag"}, 128'(tag_out), 128'(v.tag));
        $display("op %s: a=%0h b=%0h -> q=%0h r=%0h st=%0d dbz=%0d ovf=%0d tag=%0d lat=%0d",
                 nm, v.a, v.b, quotient, remainder, sticky, dbz, ovf, tag_out, lat);
    endtask

    // Same for the BPC=2 instance.
    task automatic apply_vec2(input vec_t v, input string nm);
        int guard;
        int lat;
        @(negedge clk);
        dividend_2  = v.a;
        divisor_2   = v.b;
        tag_in_2    = v.tag;
        in_valid_2  = 1'b1;
        out_ready_2 = 1'b1;
        #1;
        guard = 0;
        while (!in_ready_2 && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        chk({nm, "_in_ready"}, 128'(in_ready_2), 128'(1));
        @(posedge clk);
        @(negedge clk);
        in_valid_2 = 1'b0;
        lat = 1;
        while (!out_valid_2 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"}, 128'(lat), 128'(v.lat));
        chk({nm, "_q"}, 128'(quotient_2), 128'(v.q));
        chk({nm, "_r"}, 128'(remainder_2), 128'(v.r));
        chk({nm, "_sticky"}, 128'(sticky_2), 128'(v.st));
        chk({nm, "_tag"}, 128'(tag_out_2), 128'(v.tag));
        $display("op %s: a=%0h b=%0h -> q=%0h r=%0h st=%0d tag=%0d lat=%0d",
                 nm, v.a, v.b, quotient_2, remainder_2, sticky_2, tag_out_2, lat);
    endtask

    initial begin
        vec_t vecs[11];
        vec_t v;
        vec_t v2[2];
        logic [QW-1:0]    snap_q;
        logic [W-1:0]     snap_r;
        logic [TAG_W-1:0] snap_t;
        logic             seen;
        int               rcv;

        //            a                    b                    tag  q                   r                   st  dz  ov  lat
        vecs[0]  = '{53'h10000000000000, 53'h10000000000000, 4'd1,  56'h80000000000000, 53'h0,              0, 0, 0, 57};
        vecs[1]  = '{53'h10000000000000, 53'h18000000000000, 4'd2,  56'h55555555555555, 53'h8000000000000,  1, 0, 0, 57};
        vecs[2]  = '{53'h10000000000000, 53'h0,              4'd3,  56'hFFFFFFFFFFFFFF, 53'h0,              0, 1, 0, 1};
        vecs[3]  = '{53'h1FFFFFFFFFFFFF, 53'h8000000000000,  4'd4,  56'hFFFFFFFFFFFFFF, 53'h0,              0, 0, 1, 1};
        vecs[4]  = '{53'h1FFFFFFFFFFFFF, 53'h10000000000000, 4'd6,  56'hFFFFFFFFFFFFF8, 53'h0,              0, 0, 0, 57};
        vecs[5]  = '{53'h18000000000000, 53'h10000000000000, 4'd7,  56'hC0000000000000, 53'h0,              0, 0, 0, 57};
        vecs[6]  = '{53'h5,              53'h3,              4'd8,  56'hD5555555555555, 53'h1,              1, 0, 0, 57};
        vecs[7]  = '{53'h6,              53'h3,              4'd9,  56'hFFFFFFFFFFFFFF, 53'h0,              0, 0, 1, 1};
        vecs[8]  = '{53'h1,              53'h1,              4'd10, 56'h80000000000000, 53'h0,              0, 0, 0, 57};
        vecs[9]  = '{53'h0,              53'h7,              4'd11, 56'h0,              53'h0,              0, 0, 0, 57};
        vecs[10] = '{53'h1FFFFFFFFFFFFF, 53'h1FFFFFFFFFFFFF, 4'd12, 56'h80000000000000, 53'h0,              0, 0, 0, 57};

        v2[0] = '{53'h10000000000000, 53'h18000000000000, 4'd2, 56'h55555555555555, 53'h8000000000000, 1, 0, 0, 29};
        v2[1] = '{53'h10000000000000, 53'h10000000000000, 4'd9, 56'h80000000000000, 53'h0,             0, 0, 0, 29};

        reset       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        dividend    = '0;
        divisor     = '0;
        tag_in      = '0;
        in_valid_2  = 1'b0;
        out_ready_2 = 1'b1;
        dividend_2  = '0;
        divisor_2   = '0;
        tag_in_2    = '0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready_during", 128'(in_ready), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_quotient", 128'(quotient), 128'(0));
        chk("rst_remainder", 128'(remainder), 128'(0));
        chk("rst_flags", 128'({sticky, dbz, ovf}), 128'(0));
        chk("rst_tag_out", 128'(tag_out), 128'(0));

        // ---------------- directed table ----------------
        for (int i = 0; i < 11; i++) begin
            apply_vec(vecs[i], 1'b1, $sformatf("vec%0d", i));
        end

        // ---------------- backpressure + same-edge accept ----------------
        apply_vec(vecs[1], 1'b0, "bp_first");
        snap_q = quotient;
        snap_r = remainder;
        snap_t = tag_out;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            // Operands offered while blocked must be ignored.
            in_valid = 1'b1;
            dividend = 53'h1ABCDEF0123456;
            divisor  = 53'h0;
            #1;
            chk("bp_out_valid", 128'(out_valid), 128'(1));
            chk("bp_in_ready", 128'(in_ready), 128'(0));
            chk("bp_q_stable", 128'(quotient), 128'(snap_q));
            chk("bp_r_stable", 128'(remainder), 128'(snap_r));
            chk("bp_tag_stable", 128'(tag_out), 128'(snap_t));
        end
        v = '{53'h1FFFFFFFFFFFFF, 53'h10000000000000, 4'd5, 56'hFFFFFFFFFFFFF8, 53'h0, 0, 0, 0, 57};
        apply_vec(v, 1'b1, "bp_same_edge");

        // ---------------- reset in the middle of CALC ----------------
        @(negedge clk);
        dividend  = 53'h10000000000000;
        divisor   = 53'h10000000000000;
        tag_in    = 4'd13;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("mid_rst_accept", 128'(in_ready), 128'(1));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_in_ready_low", 128'(in_ready), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
        chk("mid_rst_quotient_cleared", 128'(quotient), 128'(0));
        seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("mid_rst_no_result", 128'(seen), 128'(0));
        apply_vec(vecs[6], 1'b1, "after_rst");

        // ---------------- BPC = 2 ----------------
        apply_vec2(v2[0], "bpc2_third");
        apply_vec2(v2[1], "bpc2_one");

        // ---------------- random with backpressure ----------------
        rcv = 0;
        fork
            begin : producer
                logic [W-1:0]   ra, rb;
                logic [107:0]   num;
                sb_t            e;
                int             wcnt;
                for (int i = 0; i < N_RND; i++) begin
                    @(negedge clk);
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(negedge clk);
                    end
                    ra = {1'b1, 20'($urandom), 32'($urandom)};
                    rb = {1'b1, 20'($urandom), 32'($urandom)};
                    dividend = ra;
                    divisor  = rb;
                    tag_in   = 4'(i);
                    in_valid = 1'b1;
                    #1;
                    wcnt = 0;
                    while (!in_ready && wcnt < 500) begin
                        @(negedge clk);
                        #1;
                        wcnt++;
                    end
                    if (!in_ready) begin
                        chk("rand_accept_timeout", 128'(0), 128'(1));
                        break;
                    end
                    num   = 108'(ra) << 55;
                    e.a   = ra;
                    e.b   = rb;
                    e.tag = 4'(i);
                    e.q   = 56'(num / 108'(rb));
                    e.r   = 53'(num % 108'(rb));
                    sb.push_back(e);
                    @(posedge clk);
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin : consumer
                sb_t          e;
                int           cyc;
                logic [127:0] lhs, rhs;
                cyc = 0;
                while (rcv < N_RND && cyc < 30000) begin
                    @(negedge clk);
                    out_ready = 1'($urandom_range(0, 1));
                    #1;
                    cyc++;
                    if (out_valid && out_ready) begin
                        if (sb.size() == 0) begin
                            chk("rand_unexpected_result", 128'(1), 128'(0));
                        end else begin
                            e   = sb.pop_front();
                            lhs = 128'(e.a) << 55;
                            rhs = 128'(quotient) * 128'(e.b) + 128'(remainder);
                            chk("rand_q", 128'(quotient), 128'(e.q));
                            chk("rand_r", 128'(remainder), 128'(e.r));
                            chk("rand_tag", 128'(tag_out), 128'(e.tag));
                            chk("rand_identity", rhs, lhs);
                            chk("rand_r_lt_b", 128'(remainder < e.b), 128'(1));
                            $display("rand #%0d: a=%0h b=%0h -> q=%0h r=%0h tag=%0d",
                                     rcv, e.a, e.b, quotient, remainder, tag_out);
                        end
                        rcv++;
                    end
                end
            end
        join
        chk("rand_count", 128'(rcv), 128'(N_RND));
        chk("rand_leftover", 128'(sb.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
